// File: rtl/aes_decipher_block.sv
// rtl/aes_decipher_block.sv - iterative AES-128 decipher datapath, one round per cycle
// Optional feature: AES_DEC_OUT_REG_EN adds a result register loaded only on the final round.
module aes_inv_sbox (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);
    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte, so entry n ends at bit 8*(255-n)+7.
    assign byte_out = INV_TABLE[{~byte_in, 3'b111} -: 8];
endmodule

module aes_decipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [127:0] block,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    output logic [127:0] result,
    output logic         ready
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    fsm_t         fsm, fsm_next;
    logic [3:0]   cnt, cnt_next;
    logic [127:0] data, data_next;
    logic [127:0] shifted, subbed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'd9:    return x8 ^ b;
            4'd11:   return x8 ^ x2 ^ b;
            4'd13:   return x8 ^ x4 ^ b;
            default: return x8 ^ x4 ^ x2;
        endcase
    endfunction

    // Byte i is row i%4, column i/4; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {
                gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
        end
        return o;
    endfunction

    assign shifted = inv_shift_rows(data);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .byte_in (shifted[127 - 8*i -: 8]),
            .byte_out(subbed[127 - 8*i -: 8])
        );
    end

    always_comb begin
        fsm_next  = fsm;
        cnt_next  = cnt;
        data_next = data;
        ready     = 1'b0;
        round_idx = 4'd10;
        case (fsm)
            IDLE: begin
                ready = 1'b1;
                if (next) begin
                    data_next = block ^ round_key;
                    cnt_next  = 4'd9;
                    fsm_next  = ROUND;
                end
            end
            ROUND: begin
                round_idx = cnt;
                data_next = inv_mix_columns(subbed ^ round_key);
                cnt_next  = cnt - 4'd1;
                if (cnt == 4'd1)
                    fsm_next = FINAL;
            end
            FINAL: begin
                round_idx = 4'd0;
                data_next = subbed ^ round_key;
                fsm_next  = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm  <= IDLE;
            cnt  <= 4'd0;
            data <= '0;
        end else begin
            fsm  <= fsm_next;
            cnt  <= cnt_next;
            data <= data_next;
        end
    end

`ifdef AES_DEC_OUT_REG_EN
    logic [127:0] out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_q <= '0;
        else if (fsm == FINAL)
            out_q <= data_next;
    end

    assign result = out_q;
`else
    assign result = data;
`endif
endmodule

// File: tb/tb_aes_decipher_block.sv
// tb/tb_aes_decipher_block.sv - self-checking bench for aes_decipher_block
`timescale 1ns/1ps
module tb_aes_decipher_block;
    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] NIST_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         next = 1'b0;
    logic [127:0] block = '0;
    logic [127:0] round_key;
    logic [127:0] result;
    logic [3:0]   round_idx;
    logic         ready;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [11];

    aes_decipher_block dut (
        .clk(clk), .reset(reset), .next(next), .block(block),
        .round_idx(round_idx), .round_key(round_key), .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    assign round_key = (round_idx <= 4'd10) ? rk[round_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input bit last);
        logic [7:0]   a [4][4];
        logic [7:0]   b [4][4];
        logic [7:0]   coef [4];
        logic [127:0] o;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) a[r][c] = s[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r][(c + r) % 4] = isbox[a[r][c]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r][c] = b[r][c] ^ k[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                a[r][c] = b[r][c];
                if (!last) begin
                    a[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++) a[r][c] = a[r][c] ^ gf_mul(coef[(j - r + 4) % 4], b[j][c]);
                end
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127 - 8*(4*c + r) -: 8] = a[r][c];
        return o;
    endfunction

    // Reference model: m_k counts completed middle rounds of the current operation.
    logic         m_busy;
    int           m_k;
    logic [127:0] m_state, m_out;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_k <= 0; m_state <= '0; m_out <= '0;
        end else if (!m_busy) begin
            if (next) begin
                m_busy <= 1'b1; m_k <= 0; m_state <= block ^ rk[10];
            end
        end else if (m_k == 9) begin
            m_state <= inv_round(m_state, rk[0], 1'b1);
            m_out   <= inv_round(m_state, rk[0], 1'b1);
            m_busy  <= 1'b0;
        end else begin
            m_state <= inv_round(m_state, rk[9 - m_k], 1'b0);
            m_k     <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("ready", ready, !m_busy);
            check("round_idx", round_idx, m_busy ? 4'(9 - m_k) : 4'd10);
`ifdef AES_DEC_OUT_REG_EN
            check("result", result, m_out);
`else
            check("result", result, m_state);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, optionally pulse next again pulse_at edges later, then wait for ready.
    task automatic run_op(input string name, input logic [127:0] ct, input logic [127:0] pt, input int pulse_at);
        int n;
        block = ct;
        next  = 1'b1;
        step();
        next  = 1'b0;
        block = ~ct;
        check({name, "_busy"}, ready, 1'b0);
        n = 0;
        while (!ready && n < 20) begin
            if (n == pulse_at - 1) begin
                next = 1'b1; block = FIPS_CT;
            end else begin
                next = 1'b0;
            end
            step();
            n++;
        end
        next = 1'b0;
        check({name, "_latency"}, 128'(n), 128'd10);
        check({name, "_result"}, result, pt);
    endtask

    initial begin
        int hits [2];
        int nhit;
        int n;

        build_sbox();
        check("sbox_00", sbox[8'h00], 8'h63);
        check("sbox_53", sbox[8'h53], 8'hed);
        check("isbox_63", isbox[8'h63], 8'h00);
        expand_key(NIST_KEY);
        check("rk10_nist", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_nist", inv_round(128'h0, 128'h0, 1'b1) ^ inv_round(128'h0, 128'h0, 1'b1), 128'h0);

        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        check("rst_ready", ready, 1'b1);
        check("rst_result", result, 128'h0);
        check("rst_idx", round_idx, 4'd10);
        step();

        run_op("nist", NIST_CT, NIST_PT, -1);
        step();
        run_op("repulse", NIST_CT, NIST_PT, 4);
        step();

        block = NIST_CT;
        next  = 1'b1;
        step();
        next  = 1'b0;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_result", result, 128'h0);
        check("abort_idx", round_idx, 4'd10);
        step();
        reset = 1'b1;
        step();

        expand_key(FIPS_KEY);
        check("rk10_fips", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        run_op("fips", FIPS_CT, FIPS_PT, -1);
        step();

        expand_key(NIST_KEY);
        block = NIST_CT;
        next  = 1'b1;
        nhit  = 0;
        hits[0] = -1;
        hits[1] = -1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (ready) begin
                if (nhit < 2) hits[nhit] = i;
                nhit++;
                check($sformatf("b2b_result_%0d", i), result, NIST_PT);
            end
        end
        next = 1'b0;
        check("b2b_count", 128'(nhit), 128'd2);
        check("b2b_first", 128'(hits[0]), 128'd10);
        check("b2b_second", 128'(hits[1]), 128'd21);
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        check("b2b_drain", ready, 1'b1);
        check("b2b_drain_result", result, NIST_PT);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES-128 decryption datapath, the inverse of the encipher block under `Top`. It takes one 128-bit ciphertext block and recovers the plaintext in 10 round cycles. Round keys come from the shared key-expansion store through a combinational round-index/round-key port. It sits beside the encipher block and uses the same `next`/`ready` handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `next`  in  1  start request; sampled only while `ready`=1.
- `block`  in  128  ciphertext, sampled on the accepting edge.
- `round_idx`  out  4  round-key index requested this cycle (10..0).
- `round_key`  in  128  key for `round_idx`, combinationally valid in the same cycle.
- `result`  out  128  plaintext; valid while `ready`=1 after a completed operation.
- `ready`  out  1  idle / result valid.

## Operation
- Byte order: bit [127:120] is byte 0. The state is column-major, as in FIPS-197.
- `InvSubBytes` uses 16 instances of the team's `aes_inv_sbox`. `InvShiftRows` and `InvMixColumns` are combinational, with GF(2^8) xtime chains (×9, ×11, ×13, ×14).
- FSM states: IDLE, ROUND, FINAL.
- **IDLE:**
  - `round_idx`=10, `ready`=1.
  - On `next`=1: `state <= block ^ round_key`, round counter ← 9, go to ROUND.
- **ROUND:**
  - `round_idx`=counter.
  - `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key)`.
  - Counter decrements. When counter=1 the next state is FINAL.
- **FINAL:**
  - `round_idx`=0.
  - `state <= InvSubBytes(InvShiftRows(state)) ^ round_key`.
  - Go to IDLE.
- `result` = `state` register (or output register; see Configuration).
- `next` during ROUND/FINAL is ignored. It is not queued.
- `next` held high across completion starts a new operation on the first IDLE cycle. `block` is resampled then.
- `block` and `round_key` changes outside their sampling cycles have no effect.
- Reset values, asynchronous, also when asserted mid-operation:
  - FSM = IDLE, counter = 0.
  - `state`/`result` = 0.
  - `ready`=1, `round_idx`=10.
  - An aborted operation produces no result.

## Timing
- Edge E0 accepts `next`. `ready` drops after E0.
- ROUND occupies E1..E9 (`round_idx` 9..1). FINAL is at E10.
- `ready`=1 and `result` valid after E10: latency 10 cycles, throughput one block per 11 cycles (accept edge plus 10).
- `round_idx` is a registered-state decode with no combinational path from `next`. The key store must return `round_key` within the same cycle.
- `result` holds until the next accepted `next`. It updates during computation (intermediate state) unless `AES_DEC_OUT_REG_EN` is defined.

## Configuration
- Macro: `AES_DEC_OUT_REG_EN`.
- Defined:
  - A separate 128-bit output register loads on the FINAL edge.
  - `result` stays at the previous plaintext (0 after reset) throughout a computation.
  - `ready` rises after E10, as before; latency is unchanged.
- Undefined:
  - `result` is driven directly from `state`.
  - It shows intermediate round values while `ready`=0.

## Test plan
- Reset with `reset`=0 for 2 cycles, then release -> `ready`=1, `result`=0, `round_idx`=10.
- NIST ECB vector: key expansion of 2b7e151628aed2a6abf7158809cf4f3c, `block`=3ad77bb40d7a3660a89ecaf32466ef97, 1-cycle `next` pulse -> `round_idx` sequence 10,9,…,0; `ready` high exactly 10 cycles after the accepting edge; `result`=6bc1bee22e409f96e93d7e117393172a.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, `block`=69c4e0d86a7b0430d8cdb78070b4c55a -> `result`=00112233445566778899aabbccddeeff.
- `next` re-pulsed at E4 with a different `block` -> ignored; the first result is correct and `ready` timing is unchanged.
- `reset` asserted at E5 -> immediate `ready`=1, `result`=0, `round_idx`=10; a following fresh operation is correct.
- `next` held high for 25 cycles using the NIST vector -> two back-to-back results 11 cycles apart, both correct. With `AES_DEC_OUT_REG_EN`, `result` is stable at the prior value during E1..E10.
